kronecker_stream: RTL and testbench

KRONECKER_STREAM -- requirements
Module: kronecker_stream

---
 rtl/kronecker_stream.sv | 167 ++++++++++++++++
 tb/tb_kronecker_stream.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronecker_stream.sv
// Streams the Kronecker product of latched matrices A (m x n) and B (p x q), one
// full-width element per cycle in row-major order. Define KRON_SIGNED_EN for two's-complement operands.
module kronecker_stream #(
    parameter int word_size     = 32,
    parameter int Amatrixrownum = 2,
    parameter int Amatrixcolnum = 2,
    parameter int Bmatrixrownum = 2,
    parameter int Bmatrixcolnum = 2,
    localparam int ROW_W = ($clog2(Amatrixrownum * Bmatrixrownum) > 0) ?
                           $clog2(Amatrixrownum * Bmatrixrownum) : 1,
    localparam int COL_W = ($clog2(Amatrixcolnum * Bmatrixcolnum) > 0) ?
                           $clog2(Amatrixcolnum * Bmatrixcolnum) : 1
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [Amatrixrownum*Amatrixcolnum*word_size-1:0] A,
    input  logic [Bmatrixrownum*Bmatrixcolnum*word_size-1:0] B,
    output logic                                              busy,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [2*word_size-1:0]                            out_data,
    output logic [ROW_W-1:0]                                  out_row,
    output logic [COL_W-1:0]                                  out_col,
    output logic                                              out_last,
    output logic                                              done
);

    localparam int M    = Amatrixrownum;
    localparam int N    = Amatrixcolnum;
    localparam int P    = Bmatrixrownum;
    localparam int Q    = Bmatrixcolnum;
    localparam int W    = word_size;
    localparam int AI_W = (M > 1) ? $clog2(M) : 1;
    localparam int AJ_W = (N > 1) ? $clog2(N) : 1;
    localparam int BI_W = (P > 1) ? $clog2(P) : 1;
    localparam int BJ_W = (Q > 1) ? $clog2(Q) : 1;

    localparam logic [AJ_W-1:0]  AJ_MAX   = AJ_W'(N - 1);
    localparam logic [BI_W-1:0]  BI_MAX   = BI_W'(P - 1);
    localparam logic [BJ_W-1:0]  BJ_MAX   = BJ_W'(Q - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M * P - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N * Q - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t          state;
    logic [W-1:0]    a_reg [M][N];
    logic [W-1:0]    b_reg [P][Q];
    logic [AI_W-1:0] ai, sel_ai;
    logic [AJ_W-1:0] aj, sel_aj;
    logic [BI_W-1:0] bi, sel_bi;
    logic [BJ_W-1:0] bj, sel_bj;
    logic [ROW_W-1:0] sel_row;
    logic [COL_W-1:0] sel_col;
    logic             sel_last;
    logic [W-1:0]     a_sel, b_sel;
    logic [2*W-1:0]   product;

    assign busy = (state != IDLE);

    // Row r = ai*p + bi and column c = aj*q + bj, so the output walks the
    // four sub-counters with bj fastest; LOAD selects element (0,0).
    always_comb begin
        sel_ai  = ai;
        sel_aj  = aj;
        sel_bi  = bi;
        sel_bj  = bj + 1'b1;
        sel_row = out_row;
        sel_col = out_col + 1'b1;
        if (bj == BJ_MAX) begin
            sel_bj = '0;
            sel_aj = aj + 1'b1;
            if (aj == AJ_MAX) begin
                sel_aj  = '0;
                sel_col = '0;
                sel_row = out_row + 1'b1;
                sel_bi  = bi + 1'b1;
                if (bi == BI_MAX) begin
                    sel_bi = '0;
                    sel_ai = ai + 1'b1;
                end
            end
        end
        if (state == LOAD) begin
            sel_ai  = '0;
            sel_aj  = '0;
            sel_bi  = '0;
            sel_bj  = '0;
            sel_row = '0;
            sel_col = '0;
        end
        sel_last = (sel_row == ROW_LAST) && (sel_col == COL_LAST);
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
                if (sel_ai == AI_W'(i) && sel_aj == AJ_W'(j)) a_sel = a_reg[i][j];
        for (int i = 0; i < P; i++)
            for (int j = 0; j < Q; j++)
                if (sel_bi == BI_W'(i) && sel_bj == BJ_W'(j)) b_sel = b_reg[i][j];
    end

`ifdef KRON_SIGNED_EN
    assign product = {{W{a_sel[W-1]}}, a_sel} * {{W{b_sel[W-1]}}, b_sel};
`else
    assign product = {{W{1'b0}}, a_sel} * {{W{1'b0}}, b_sel};
`endif

    // NOTE: operand registers are only read after a start has loaded them, so
    // they carry no reset; only control state and visible outputs are cleared.
    always_ff @(posedge clk) begin
        if (start && state == IDLE && !rst) begin
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    a_reg[i][j] <= A[(M*N - 1 - (i*N + j))*W +: W];
            for (int i = 0; i < P; i++)
                for (int j = 0; j < Q; j++)
                    b_reg[i][j] <= B[(P*Q - 1 - (i*Q + j))*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            ai        <= '0;
            aj        <= '0;
            bi        <= '0;
            bj        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) state <= LOAD;
                LOAD, RUN: begin
                    if (state == LOAD || (out_ready && !out_last)) begin
                        state     <= RUN;
                        out_valid <= 1'b1;
                        out_data  <= product;
                        out_row   <= sel_row;
                        out_col   <= sel_col;
                        out_last  <= sel_last;
                        ai        <= sel_ai;
                        aj        <= sel_aj;
                        bi        <= sel_bi;
                        bj        <= sel_bj;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kronecker_stream.sv
// Self-checking bench for kronecker_stream: a 2x2 (x) 2x2 instance against a
// behavioural Kronecker model, plus a 1x3 (x) 2x1 instance for odd shapes.
module tb_kronecker_stream;

    logic         clk = 1'b0;
    logic         rst, start, out_ready;
    logic [127:0] a_in, b_in;
    logic         busy, out_valid, out_last, done;
    logic [63:0]  out_data;
    logic [1:0]   out_row, out_col;

    logic         start1, ready1;
    logic [95:0]  a1;
    logic [63:0]  b1;
    logic         busy1, valid1, last1, done1;
    logic [63:0]  data1;
    logic [0:0]   row1;
    logic [1:0]   col1;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ma [2][2];
    logic [31:0] mb [2][2];

    always #5 clk = ~clk;

    kronecker_stream dut0 (
        .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .done(done)
    );

    kronecker_stream #(
        .word_size(32), .Amatrixrownum(1), .Amatrixcolnum(3),
        .Bmatrixrownum(2), .Bmatrixcolnum(1)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .out_valid(valid1), .out_ready(ready1),
        .out_data(data1), .out_row(row1), .out_col(col1),
        .out_last(last1), .done(done1)
    );

    function automatic logic [127:0] pack(input logic [31:0] m [2][2]);
        return {m[0][0], m[0][1], m[1][0], m[1][1]};
    endfunction

    // Kronecker element (r,c) = A[r/p][c/q] * B[r%p][c%q] at full width.
    function automatic logic [63:0] ref_elem(input int r, input int c);
        logic [31:0] a, b;
        a = ma[r / 2][c / 2];
        b = mb[r % 2][c % 2];
`ifdef KRON_SIGNED_EN
        return 64'(longint'(int'(a)) * longint'(int'(b)));
`else
        return 64'(longint'({32'd0, a}) * longint'({32'd0, b}));
`endif
    endfunction

    task automatic randomize_mats();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = $urandom;
                mb[i][j] = $urandom;
            end
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic run_stream(input string tag, input int mode, input bit chain);
        int          idx, cyc;
        bit          rdy, stalled;
        logic [63:0] e, h_data;
        logic [1:0]  h_row, h_col;
        logic        h_last;
        idx = 0; cyc = 0; stalled = 0;
        h_data = '0; h_row = '0; h_col = '0; h_last = 1'b0;
        a_in = pack(ma); b_in = pack(mb);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s load: busy=%b valid=%b done=%b, want 1 0 0", tag, busy, out_valid, done);
        end
        start = 1'b0;
        a_in = {$urandom, $urandom, $urandom, $urandom};
        b_in = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s first_valid: valid=%b, want 1", tag, out_valid);
        end
        while (idx < 16 && cyc < 400) begin
            if (stalled) begin
                vectors++;
                if ({out_data, out_row, out_col, out_last} !== {h_data, h_row, h_col, h_last}) begin
                    miscompares++;
                    $display("FAIL %s hold: got %h r%0d c%0d l%b, want %h r%0d c%0d l%b",
                             tag, out_data, out_row, out_col, out_last, h_data, h_row, h_col, h_last);
                end
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = rdy;
            start = 1'($urandom_range(0, 1));
            a_in = {$urandom, $urandom, $urandom, $urandom};
            b_in = {$urandom, $urandom, $urandom, $urandom};
            vectors++;
            if (out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL %s valid_drop: valid=%b at element %0d, want 1", tag, out_valid, idx);
            end else if (rdy) begin
                e = ref_elem(idx / 4, idx % 4);
                vectors++;
                if (out_data !== e || out_row !== 2'(idx / 4) || out_col !== 2'(idx % 4) ||
                    out_last !== (idx == 15)) begin
                    miscompares++;
                    $display("FAIL %s elem%0d: got %h r%0d c%0d l%b, want %h r%0d c%0d l%b",
                             tag, idx, out_data, out_row, out_col, out_last,
                             e, idx / 4, idx % 4, idx == 15);
                end
                idx++;
            end
            stalled = !rdy;
            h_data = out_data; h_row = out_row; h_col = out_col; h_last = out_last;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1;
        vectors++;
        if (idx != 16) begin
            miscompares++;
            $display("FAIL %s timeout: accepted %0d elements, want 16", tag, idx);
        end
        vectors++;
        if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: valid=%b done=%b busy=%b, want 0 1 0", tag, out_valid, done, busy);
        end
        if (!chain) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL %s done_pulse: done=%b, want 0", tag, done);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        start1 = 1'b0; ready1 = 1'b0; a1 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, out_valid, out_last, done, out_data, out_row, out_col} !== '0) begin
            miscompares++;
            $display("FAIL reset: busy=%b valid=%b last=%b done=%b data=%h row=%0d col=%0d, want all 0",
                     busy, out_valid, out_last, done, out_data, out_row, out_col);
        end
        vectors++;
        if ({busy1, valid1, last1, done1} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset_small: flags=%b, want 0000", {busy1, valid1, last1, done1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed(input int mode, input bit chain);
        ma = '{'{32'd1, 32'd2}, '{32'd3, 32'd4}};
        mb = '{'{32'd0, 32'd5}, '{32'd6, 32'd7}};
        run_stream(mode == 0 ? "directed" : "backpressure", mode, chain);
    endtask

    task automatic test_max_operands();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = 32'hFFFF_FFFF;
                mb[i][j] = 32'hFFFF_FFFF;
            end
        run_stream("max_operands", 2, 1'b0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            randomize_mats();
            run_stream("random", 2, t < 3);
        end
    endtask

    task automatic test_abort();
        randomize_mats();
        a_in = pack(ma); b_in = pack(mb);
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if ({busy, out_valid, out_last, done, out_data, out_row, out_col} !== '0) begin
            miscompares++;
            $display("FAIL abort_reset: busy=%b valid=%b last=%b done=%b data=%h row=%0d col=%0d, want all 0",
                     busy, out_valid, out_last, done, out_data, out_row, out_col);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet: cycle %0d done=%b valid=%b busy=%b, want 0 0 0",
                         k, done, out_valid, busy);
            end
        end
        randomize_mats();
        run_stream("restart", 0, 1'b0);
    endtask

    task automatic test_small_shape();
        int unsigned exp6 [6] = '{4, 8, 12, 5, 10, 15};
        a1 = {32'd1, 32'd2, 32'd3};
        b1 = {32'd4, 32'd5};
        start1 = 1'b1; ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (valid1 !== 1'b1 || data1 !== 64'(exp6[k]) || row1 !== 1'(k / 3) ||
                col1 !== 2'(k % 3) || last1 !== (k == 5)) begin
                miscompares++;
                $display("FAIL small_elem%0d: got v%b %0d r%0d c%0d l%b, want v1 %0d r%0d c%0d l%b",
                         k, valid1, data1, row1, col1, last1, exp6[k], k / 3, k % 3, k == 5);
            end
            @(negedge clk);
        end
        vectors++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL small_done: done=%b valid=%b, want 1 0", done1, valid1);
        end
    endtask

`ifdef KRON_SIGNED_EN
    task automatic test_signed();
        randomize_mats();
        ma[0][0] = 32'hFFFF_FFFF;
        ma[0][1] = 32'hFFFF_FFFE;
        mb[0][0] = 32'hFFFF_FFFF;
        mb[0][1] = 32'd3;
        run_stream("signed", 0, 1'b0);
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed(0, 1'b1);
        test_directed(1, 1'b0);
        test_max_operands();
        test_random();
        test_abort();
        test_small_shape();
`ifdef KRON_SIGNED_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
